// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared constants and state type for the 8-slot TDM
//                receive path (demultiplexer and its slot decoder).
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  // Frame geometry: fixed at eight slots for this revision.
  localparam int N_SLOTS = 8;
  localparam int SEL_W   = 3;

  // Slot indices with special meaning in the frame walk.
  localparam logic [SEL_W-1:0] C_SLOT0     = '0;
  localparam logic [SEL_W-1:0] C_SLOT_LAST = SEL_W'(N_SLOTS - 1);

  // State encodings kept as plain constants so legacy code can compare
  // against them directly; the enum below is built from the same values.
  localparam logic [0:0] C_ST_IDLE = 1'b0;
  localparam logic [0:0] C_ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = C_ST_IDLE,
    RUN  = C_ST_RUN
  } state_e;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_demux8_slot_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux8_slot_decoder
//  Description : 3-to-8 one-hot decoder turning the current slot index into
//                shadow-register write enables, gated by in_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
import tdm_pkg::*;

module tdm_demux8_slot_decoder (
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic [0:N_SLOTS-1] wr_en
);

  // One enable per slot; only the slot addressed by sel fires, and only on
  // a valid cycle.
  generate
    for (genvar k = 0; k < N_SLOTS; k++) begin : g_dec
      assign wr_en[k] = in_valid && (sel == SEL_W'(k));
    end
  endgenerate

endmodule : tdm_demux8_slot_decoder
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux8
//  Description : Receive-side TDM demultiplexer. Collects one serial bit per
//                valid cycle into an 8-slot shadow register and publishes the
//                completed frame as a parallel word. The slot counter is
//                exported so a paired 8:1 mux can share it.
//  Revision    : 1.0 - initial release
// ============================================================================
import tdm_pkg::*;

module tdm_demux8 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               frame_start,
  output logic [SEL_W-1:0]   sel,
  output logic [0:N_SLOTS-1] out_word,
  output logic               out_valid,
  output logic               frame_err
);

  state_e               r_state;
  logic [SEL_W-1:0]     r_sel;
  logic [0:N_SLOTS-1]   r_shadow;
  logic [0:N_SLOTS-1]   r_out_word;
  logic                 r_out_valid;
  logic                 r_frame_err;

  state_e               w_state_nxt;
  logic [SEL_W-1:0]     w_sel_nxt;
  logic [0:N_SLOTS-1]   w_shadow_nxt;
  logic [0:N_SLOTS-1]   w_wr_en;
  logic                 w_done;
  logic                 w_err;

  tdm_demux8_slot_decoder u_slot_decoder (
    .sel      (r_sel),
    .in_valid (in_valid),
    .wr_en    (w_wr_en)
  );

  // Next-state logic: frame lock, slot walk, resync and completion detect.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_shadow_nxt = r_shadow;
    w_done       = 1'b0;
    w_err        = 1'b0;
    if (in_valid) begin
      case (r_state)
        IDLE: begin
          // Unlocked bits are dropped until a frame marker arrives.
          if (frame_start) begin
            w_shadow_nxt          = '0;
            w_shadow_nxt[C_SLOT0] = in_bit;
            w_sel_nxt             = C_SLOT0 + SEL_W'(1);
            w_state_nxt           = RUN;
          end
        end
        RUN: begin
          if (frame_start && (r_sel != C_SLOT0)) begin
            // Marker arrived mid-frame: drop the partial frame and treat
            // this bit as the new slot 0.
            w_err                 = 1'b1;
            w_shadow_nxt          = '0;
            w_shadow_nxt[C_SLOT0] = in_bit;
            w_sel_nxt             = C_SLOT0 + SEL_W'(1);
          end else begin
            for (int k = 0; k < N_SLOTS; k++) begin
              if (w_wr_en[k]) begin
                w_shadow_nxt[k] = in_bit;
              end
            end
            w_done    = (r_sel == C_SLOT_LAST);
            w_sel_nxt = r_sel + SEL_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_sel_nxt   = C_SLOT0;
        end
      endcase
    end
  end

  // State, counter, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= C_SLOT0;
      r_shadow    <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_shadow    <= w_shadow_nxt;
      r_out_valid <= w_done;
      r_frame_err <= w_err;
      if (w_done) begin
        r_out_word <= w_shadow_nxt;
      end
    end
  end

  assign sel       = r_sel;
  assign out_word  = r_out_word;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;

endmodule : tdm_demux8
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux8
//  Description : Self-checking bench for tdm_demux8. Stimulus feeds a
//                frame-level reference model that queues expected events;
//                an independent monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
import tdm_pkg::*;

module tb_tdm_demux8;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_bit;
  logic               frame_start;
  logic [SEL_W-1:0]   sel;
  logic [0:N_SLOTS-1] out_word;
  logic               out_valid;
  logic               frame_err;

  typedef struct {
    bit         is_err;
    logic [0:7] word;
  } ev_t;

  ev_t        exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         vcount  = 0;
  logic [0:7] exp_word = '0;
  bit         m_locked = 0;
  bit         m_bits[$];

  tdm_demux8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .frame_start (frame_start),
    .sel         (sel),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .frame_err   (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_bits.delete();
    exp_q.delete();
    exp_word = '0;
  endtask

  // Apply one cycle of input, update the frame model, then check sel.
  task automatic step(input bit v, input bit b, input bit fs);
    ev_t e;
    in_valid    = v;
    in_bit      = b;
    frame_start = fs;
    if (rst_n && v) begin
      if (!m_locked) begin
        if (fs) begin
          m_bits.delete();
          m_bits.push_back(b);
          m_locked = 1;
        end
      end else if (fs && m_bits.size() != 0) begin
        e.is_err = 1;
        e.word   = '0;
        exp_q.push_back(e);
        m_bits.delete();
        m_bits.push_back(b);
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == N_SLOTS) begin
          e.is_err = 0;
          for (int k = 0; k < N_SLOTS; k++) e.word[k] = m_bits[k];
          exp_q.push_back(e);
          m_bits.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    chk("sel", 32'(sel), m_locked ? 32'(m_bits.size()) : 32'd0);
  endtask

  // Monitor: pop expected events whenever the DUT pulses an output.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (out_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({out_valid, frame_err}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", 32'({out_valid, frame_err}), e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) begin
            exp_word = e.word;
            vcount++;
          end
        end
      end
      chk("out_word", 32'(out_word), 32'(exp_word));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:7] pat;
    logic [0:7] saved;
    logic [7:0] d;
    logic [0:7] dl;
    int         vc0;
    bit         v;

    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; frame_start = 1'b0;
    @(posedge clk);
    #1;

    // Reset with traffic present, then unlocked bits are dropped.
    repeat (4) step(1'b1, 1'($urandom % 2), 1'($urandom % 2));
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_word", 32'(out_word), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    repeat (10) step(1'b1, 1'($urandom % 2), 1'b0);

    // Single frame, in_valid held high.
    pat = 8'b1011_0010;
    for (int k = 0; k < N_SLOTS; k++) step(1'b1, pat[k], k == 0);
    chk("single_word", 32'(out_word), 32'(pat));
    chk("single_valid", 32'(out_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("single_valid_drop", 32'(out_valid), 32'd0);

    // Two back-to-back frames with gaps, no frame_start.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
        step(1'b1, 1'($urandom % 2), 1'b0);
      end
    end
    step(1'b0, 1'b0, 1'b0);

    // Resync: frame_start at sel=5.
    saved = out_word;
    for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom % 2), k == 0);
    step(1'b1, 1'b1, 1'b1);
    chk("resync_err", 32'(frame_err), 32'd1);
    chk("resync_no_valid", 32'(out_valid), 32'd0);
    chk("resync_hold", 32'(out_word), 32'(saved));
    for (int k = 1; k < N_SLOTS; k++) step(1'b1, 1'($urandom % 2), 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Async reset at sel=4, between edges.
    for (int k = 0; k < 4; k++) step(1'b1, 1'($urandom % 2), 1'b0);
    chk("pre_reset_sel", 32'(sel), 32'd4);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_word", 32'(out_word), 32'd0);
    chk("arst_flags", 32'({out_valid, frame_err}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) step(1'b1, 1'($urandom % 2), 1'b0);

    // Mux loopback: frame_start tied to sel==0.
    d = 8'b0110_1001;
    for (int k = 0; k < N_SLOTS; k++) dl[k] = d[k];
    vc0 = vcount;
    repeat (200) begin
      v = ($urandom % 4) != 0;
      step(v, d[sel], sel == C_SLOT0);
    end
    chk("loop_word", 32'(out_word), 32'(dl));
    chk("loop_frames", 32'((vcount - vc0) >= 10), 32'd1);

    // Random traffic with occasional markers anywhere.
    repeat (1500) step(($urandom % 3) != 0, 1'($urandom % 2), ($urandom % 16) == 0);

    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tdm_demux8
`default_nettype wire

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
Time-division demultiplexer that receives the serial bit stream produced by an 8:1 mux whose select walks slots 0..7. It reassembles each 8-slot frame into a parallel word.
- Publishes its current slot index so a paired mux select can be driven from the same counter.
- Sits at the receive end of the 8-channel TDM link, the inverse of the mux/decoder path.

Parameters:
N_SLOTS, 8, slots per frame; fixed at 8 for this revision.
SEL_W, 3, slot index width; log2(N_SLOTS).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  in_bit is valid this cycle; one slot consumed per valid cycle
in_bit  input  1  serial data bit for the current slot
frame_start  input  1  qualified by in_valid; marks in_bit as slot 0
sel  output  SEL_W  slot index the next valid bit is written to
out_word  output  [0:N_SLOTS-1]  last complete frame; out_word[k] = bit received in slot k
out_valid  output  1  one-cycle pulse: out_word updated
frame_err  output  1  one-cycle pulse: frame_start seen mid-frame, partial frame discarded

Behaviour:
Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low.

Reset values: state=IDLE, sel=0, shadow=0, out_word=0, out_valid=0, frame_err=0. Reset mid-frame discards the partial frame.

States:
- IDLE: unsynchronised. Bits with in_valid and no frame_start are dropped, and sel stays 0. On in_valid && frame_start: shadow[0]<=in_bit, sel<=1, go to RUN.
- RUN: locked. Each in_valid cycle: shadow[sel]<=in_bit, sel<=sel+1.

Frame completion:
- On the in_valid cycle with sel==7, register out_word<={shadow[0:6], in_bit}.
- out_valid is 1 in the following cycle only.
- sel wraps to 0 and the block stays in RUN (back-to-back frames, no bubble).

frame_start handling in RUN:
- At sel==0: optional; a frame with or without it is accepted.
- At sel!=0 with in_valid: frame_err pulses the next cycle and the partial shadow is discarded. The current bit is taken as slot 0: shadow[0]<=in_bit, sel<=1. out_word and out_valid are unaffected.
- Without in_valid it is ignored.

General rules:
- in_valid low: all state holds; gaps of any length are allowed mid-frame.
- out_word holds its value between completions; only completion writes it.
- out_valid and frame_err are never high together.
- Latency: 1 cycle from the clock edge sampling the slot-7 bit to out_valid/out_word visible.
- No back-pressure. A consumer must take out_word within 8 valid cycles of out_valid.

Decomposition:
- Package tdm_pkg holds:
  - N_SLOTS, SEL_W
  - state enum {IDLE, RUN}
  - the slot-0 index constant
- Natural sub-module: slot_decoder, a 3-to-8 one-hot decoder. It takes sel and produces the shadow write enables, gated by in_valid.
- Counter, FSM and output register stay in tdm_demux8.

Test Plan:
1. Reset then idle: rst_n low with traffic present -> sel=0, out_word=8'h00, out_valid=0. Bits without frame_start stay dropped while IDLE.
2. Single frame: frame_start on slot 0, bits 1,0,1,1,0,0,1,0 with in_valid held high. Required: out_word[0:7]=1,0,1,1,0,0,1,0, out_valid exactly one cycle after bit 7, and sel sequence 1..7,0.
3. Back-to-back frames with in_valid gaps of 0-3 cycles inserted mid-frame, frame_start only on the first frame. Required: two correct words, two out_valid pulses, and sel holding during each gap.
4. Resync: frame_start at sel=5. Required: frame_err pulse and no out_valid. The next out_word is built from the new slot 0 onward, and the prior out_word is unchanged until then.
5. Async reset at sel=4 in RUN, mid-cycle between edges. Required: outputs clear immediately and state=IDLE. The next 8 bits without frame_start produce no out_valid.
6. Mux loopback: an 8:1 mux driven by sel with d=8'b0110_1001, frame_start tied to (sel==0). Required: out_word equals d every frame, continuously.
